// File: rtl/ls_usb_pkg.sv
// Shared definitions for the low-speed USB transmit path: FSM encoding,
// well-known packet bytes and the default byte guard.
package ls_usb_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GAP  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ADV  = 3'd3;
    localparam logic [2:0] ST_EOP  = 3'd4;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_ACK   = 8'hd2;
    localparam logic [7:0] PID_DATA0 = 8'hc3;
    localparam logic [7:0] PID_DATA1 = 8'h4b;

    localparam int MAX_BYTES_DEFAULT = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ls_usb_tx_sched.sv
// Transmit sequencer: turnaround gap, byte-by-byte hand-off from the
// response core to the serializer, then EOP and line release.
module ls_usb_tx_sched
    import ls_usb_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_BYTES  = MAX_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pkt,
    input  logic [7:0] sbyte,
    input  logic       last_pkt_byte,
    input  logic       rx_active,
    output logic       show_next,
    output logic [7:0] ser_data,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_eop,
    input  logic       ser_done,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       pkt_sent,
    output logic       len_err,
    output logic [7:0] drop_cnt
);

    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] MAX_CNT  = 5'(MAX_BYTES);

    logic [2:0] state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [4:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       len_err_q, len_err_d;
    logic       show_next_q, ser_valid_q, ser_eop_q;
    logic       tx_oe_q, tx_busy_q, pkt_sent_q;
    logic       handshake;

    assign handshake = (state_q == ST_DATA) && ser_ready;

    // Next-state, counter and sticky-flag decisions for the transmit FSM.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        byte_cnt_d = byte_cnt_q;
        drop_cnt_d = drop_cnt_q;
        len_err_d  = len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pkt) begin
                    if (rx_active) begin
                        drop_cnt_d = sat_inc8(drop_cnt_q);
                    end else begin
                        state_d    = ST_GAP;
                        gap_cnt_d  = GAP_INIT;
                        byte_cnt_d = '0;
                    end
                end
            end
            ST_GAP: begin
                if (rx_active) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == 8'd0) begin
                    state_d = ST_DATA;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (last_pkt_byte) begin
                        state_d = ST_EOP;
                    end else if ((byte_cnt_q + 5'd1) == MAX_CNT) begin
                        state_d   = ST_EOP;
                        len_err_d = 1'b1;
                    end else begin
                        state_d = ST_ADV;
                    end
                end
            end
            ST_ADV: begin
                state_d = ST_DATA;
            end
            ST_EOP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            show_next_q <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_eop_q   <= 1'b0;
            tx_oe_q     <= 1'b0;
            tx_busy_q   <= 1'b0;
            pkt_sent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            len_err_q   <= len_err_d;
            show_next_q <= (state_d == ST_ADV);
            ser_valid_q <= (state_d == ST_DATA);
            ser_eop_q   <= (state_d == ST_EOP);
            tx_oe_q     <= (state_d == ST_DATA) || (state_d == ST_ADV) || (state_d == ST_EOP);
            tx_busy_q   <= (state_d != ST_IDLE);
            pkt_sent_q  <= (state_q == ST_EOP) && ser_done;
        end
    end

    // The core only presents a new byte one cycle after show_next, i.e. in
    // the DATA cycle itself, so the byte is passed through under the
    // registered valid rather than captured a cycle early.
    assign ser_data  = ser_valid_q ? sbyte : 8'h00;
    assign ser_valid = ser_valid_q;
    assign show_next = show_next_q;
    assign ser_eop   = ser_eop_q;
    assign tx_oe     = tx_oe_q;
    assign tx_busy   = tx_busy_q;
    assign pkt_sent  = pkt_sent_q;
    assign len_err   = len_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ls_usb_tx_sched.sv
// Scoreboard bench for ls_usb_tx_sched: a small core model feeds bytes,
// expected bytes are queued at stimulus time and popped by a monitor.
module tb_ls_usb_tx_sched;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_pkt;
    logic [7:0] sbyte;
    logic       last_pkt_byte;
    logic       rx_active;
    logic       show_next;
    logic [7:0] ser_data;
    logic       ser_valid;
    logic       ser_ready = 1'b1;
    logic       ser_eop;
    logic       ser_done = 1'b0;
    logic       tx_oe;
    logic       tx_busy;
    logic       pkt_sent;
    logic       len_err;
    logic [7:0] drop_cnt;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    logic [7:0] mem [32];
    int         pktLen = 0;
    bit         lastEn = 1'b0;
    int         corePtr = 0;
    bit         rewindReq = 1'b0;

    logic [7:0] expQ [$];
    int         expShow = 0;
    int         startCyc = 0;
    int         stallIdx = 0;
    int         stallLeft = 0;
    int         eopWait = 0;

    int         showCnt = 0;
    int         eopCnt = 0;
    bit         prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;

    logic [7:0] ackPkt  [$];
    logic [7:0] descPkt [$];
    logic [7:0] bpPkt   [$];
    logic [7:0] guardPkt[$];

    ls_usb_tx_sched #(.GAP_CYCLES(GAP), .MAX_BYTES(16)) dut (
        .clk(clk), .rst(rst), .start_pkt(start_pkt), .sbyte(sbyte),
        .last_pkt_byte(last_pkt_byte), .rx_active(rx_active),
        .show_next(show_next), .ser_data(ser_data), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_eop(ser_eop), .ser_done(ser_done),
        .tx_oe(tx_oe), .tx_busy(tx_busy), .pkt_sent(pkt_sent),
        .len_err(len_err), .drop_cnt(drop_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: byte pointer advances on show_next, rewinds on request.
    always @(posedge clk) begin
        if (rewindReq) corePtr <= 0;
        else if (show_next) corePtr <= corePtr + 1;
    end
    assign sbyte         = mem[corePtr[4:0]];
    assign last_pkt_byte = lastEn && (corePtr == pktLen - 1);

    // Serializer ready: drops for stallLeft cycles while offering byte stallIdx.
    always @(negedge clk) begin
        if (ser_valid && corePtr == stallIdx && stallLeft > 0) begin
            ser_ready = 1'b0;
            stallLeft--;
        end else begin
            ser_ready = 1'b1;
        end
    end

    // Serializer EOP: answers a held ser_eop with a done pulse on its third cycle.
    always @(negedge clk) begin
        if (ser_done) begin
            ser_done = 1'b0;
        end else if (ser_eop) begin
            if (eopWait == 2) begin
                ser_done = 1'b1;
                eopWait  = 0;
            end else begin
                eopWait++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor: pops expected bytes on each handshake and audits per-packet counts.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            showCnt   = 0;
            eopCnt    = 0;
            prevStall = 1'b0;
        end else begin
            if (prevStall && ser_valid) checkOutput("stall_stable", {24'd0, ser_data}, {24'd0, prevData});
            prevStall = ser_valid && !ser_ready;
            prevData  = ser_data;
            if (ser_valid && ser_ready) begin
                if (expQ.size() == 0) failNow("unexpected_byte");
                else checkOutput("ser_data", {24'd0, ser_data}, {24'd0, expQ.pop_front()});
            end
            if (show_next) showCnt++;
            if (ser_eop) begin
                eopCnt++;
                checkOutput("eop_oe", {31'd0, tx_oe}, 32'd1);
                checkOutput("eop_novalid", {31'd0, ser_valid}, 32'd0);
            end
            if (pkt_sent) begin
                checkOutput("show_next_count", showCnt, expShow);
                checkOutput("eop_hold_cycles", eopCnt, 32'd3);
                checkOutput("queue_drained", expQ.size(), 32'd0);
                checkOutput("oe_released", {31'd0, tx_oe}, 32'd0);
                showCnt = 0;
                eopCnt  = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] bytes[$], input bit lastFlag,
                                 input int expN, input int shows);
        for (int i = 0; i < 32; i++) mem[i] = (i < bytes.size()) ? bytes[i] : 8'h00;
        pktLen  = bytes.size();
        lastEn  = lastFlag;
        expShow = shows;
        for (int i = 0; i < expN; i++) expQ.push_back(bytes[i]);
        rewindReq = 1'b1;
        @(negedge clk);
        rewindReq = 1'b0;
        start_pkt = 1'b1;
        startCyc  = cyc;
        @(negedge clk);
        start_pkt = 1'b0;
    endtask

    task automatic checkFirstOffer();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #2;
            if (ser_valid) begin
                seen = 1'b1;
                checkOutput("first_valid_cycle", cyc, startCyc + 1 + GAP);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) failNow("first_valid_timeout");
    endtask

    task automatic waitPktSent(input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk);
            #2;
            if (pkt_sent) seen = 1'b1;
        end
        if (!seen) failNow("pkt_sent_timeout");
        @(negedge clk);
        #2;
        checkOutput("idle_after_pkt", {30'd0, tx_busy, tx_oe}, 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {13'd0, tx_oe, ser_valid, ser_eop, show_next, tx_busy,
                           pkt_sent, len_err, ser_data, drop_cnt}, 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start_pkt = 1'b0; rx_active = 1'b0;
        ackPkt   = '{8'h80, 8'hd2};
        descPkt  = '{8'h80, 8'h4b, 8'h12, 8'h01, 8'h00, 8'h01, 8'hff, 8'h00,
                     8'h00, 8'h08, 8'h23, 8'hf3};
        bpPkt    = '{8'h80, 8'hc3, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 20; i++) guardPkt.push_back(8'(8'h30 + i));
        repeat (3) @(negedge clk);
        #2;
        checkAllZero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] ACK packet");
        applyStimulus(ackPkt, 1'b1, 2, 1);
        checkFirstOffer();
        waitPktSent(100);

        $display("[TB] 12-byte descriptor");
        applyStimulus(descPkt, 1'b1, 12, 11);
        checkFirstOffer();
        waitPktSent(200);
        checkOutput("desc_len_err", {31'd0, len_err}, 32'd0);

        $display("[TB] backpressure on byte 3");
        stallIdx = 2; stallLeft = 3;
        applyStimulus(bpPkt, 1'b1, 5, 4);
        waitPktSent(200);

        $display("[TB] start while rx_active");
        rx_active = 1'b1; start_pkt = 1'b1;
        @(negedge clk);
        rx_active = 1'b0; start_pkt = 1'b0;
        #2;
        checkOutput("drop_cnt_inc", {24'd0, drop_cnt}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            checkOutput("dropped_no_oe", {30'd0, tx_oe, tx_busy}, 32'd0);
        end

        $display("[TB] rx_active abort in gap");
        applyStimulus(ackPkt, 1'b1, 0, 0);
        rx_active = 1'b1;
        @(negedge clk);
        rx_active = 1'b0;
        #2;
        checkOutput("abort_idle", {31'd0, tx_busy}, 32'd0);
        checkOutput("abort_drop_same", {24'd0, drop_cnt}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            checkOutput("abort_no_valid", {30'd0, ser_valid, tx_oe}, 32'd0);
        end

        $display("[TB] byte guard");
        applyStimulus(guardPkt, 1'b0, 16, 15);
        waitPktSent(300);
        checkOutput("guard_len_err", {31'd0, len_err}, 32'd1);
        applyStimulus(ackPkt, 1'b1, 2, 1);
        waitPktSent(100);
        checkOutput("len_err_sticky", {31'd0, len_err}, 32'd1);

        $display("[TB] reset during byte 5");
        stallIdx = 4; stallLeft = 1000;
        applyStimulus(descPkt, 1'b1, 4, 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (ser_valid && corePtr == 4) seen = 1'b1;
        end
        if (!seen) failNow("byte5_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkAllZero("mid_pkt_reset");
        checkOutput("reset_queue_drained", expQ.size(), 32'd0);
        stallLeft = 0;
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(ackPkt, 1'b1, 2, 1);
        checkFirstOffer();
        waitPktSent(100);
        checkOutput("post_reset_len_err", {31'd0, len_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/ls_usb_tx_sched.md
Name: ls_usb_tx_sched

Overview:
- Transmit sequencer between the low-speed USB response core and the bit-level serializer/NRZI line driver.
- On the core's start_pkt it waits a bus turnaround gap, then asserts the line output enable.
- It then moves the core's byte stream to the serializer one byte at a time. The stream already includes the SYNC byte at position 0.
- After each accepted byte except the last it pulses show_next to advance the core. After the last byte it requests EOP and releases the line.

Parameters:
- GAP_CYCLES, 16: clk cycles of turnaround between start_pkt and the first byte offered; legal range 1..255.
- MAX_BYTES, 16: byte guard; EOP is forced after this many bytes if last_pkt_byte never appears.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_pkt  in  1  one-cycle pulse from the core: a response packet is ready
- sbyte  in  8  current byte from the core; valid 1 cycle after any show_next
- last_pkt_byte  in  1  sbyte is the final byte of the packet
- rx_active  in  1  receiver currently sees bus activity
- show_next  out  1  one-cycle pulse: core advances its byte pointer
- ser_data  out  8  byte offered to the serializer
- ser_valid  out  1  ser_data valid
- ser_ready  in  1  serializer accepts the byte when ser_valid & ser_ready
- ser_eop  out  1  EOP request, held until ser_done
- ser_done  in  1  one-cycle pulse: serializer finished EOP
- tx_oe  out  1  line driver enable
- tx_busy  out  1  block not in IDLE
- pkt_sent  out  1  one-cycle pulse on completed transmission
- len_err  out  1  sticky: byte guard tripped; cleared only by rst
- drop_cnt  out  8  saturating count of start_pkt pulses ignored

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- rst mid-packet: state returns to IDLE at the next edge. tx_oe, ser_valid and ser_eop drop in that same cycle. No show_next is issued.
- All outputs are registered. Five states: IDLE, GAP, DATA, ADV, EOP.
- IDLE:
  - start_pkt & !rx_active -> GAP; gap_cnt <= GAP_CYCLES-1; byte_cnt <= 0.
  - start_pkt & rx_active -> stay in IDLE; drop_cnt += 1, saturating at 255.
- GAP:
  - rx_active=1 -> IDLE (abort, no drop_cnt change).
  - Otherwise, when gap_cnt==0 -> DATA; else gap_cnt -= 1.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- DATA:
  - tx_oe=1, ser_valid=1, ser_data=sbyte, sampled each cycle.
  - On handshake: byte_cnt += 1. The next state is decided in this order:
    1. last_pkt_byte=1 -> EOP.
    2. byte_cnt+1 == MAX_BYTES -> EOP and set len_err.
    3. Otherwise -> ADV.
  - Without ser_ready, ser_data/ser_valid stay stable.
- ADV:
  - show_next=1 for this single cycle; ser_valid=0; -> DATA.
  - The one-cycle bubble guarantees the core's sbyte and last_pkt_byte have updated before the next offer.
- EOP:
  - tx_oe=1, ser_eop=1, ser_valid=0.
  - On ser_done -> IDLE, with pkt_sent=1 and tx_oe=0 in the following cycle.
- rx_active is ignored in DATA, ADV and EOP: the block owns the bus.
- start_pkt while tx_busy is ignored and not counted.
- Timing: first ser_valid is in cycle T+1+GAP_CYCLES for start_pkt in cycle T. Minimum spacing between byte offers is 2 cycles.
- byte_cnt is 5 bits wide and compared against MAX_BYTES without wrap.
- show_next pulses per packet = bytes sent - 1.

Decomposition:
- Shared package ls_usb_pkg holds:
  - state encoding (IDLE=0, GAP=1, DATA=2, ADV=3, EOP=4)
  - SYNC_BYTE = 8'h80
  - PID constants: ACK 8'hd2, DATA0 8'hc3, DATA1 8'h4b
  - the MAX_BYTES default
- No sub-module. The gap counter, byte counter and saturating drop counter are small inline counters in the single FSM module.

Test Plan:
- ACK, GAP_CYCLES=4:
  - Stimulus: core stream 0x80, 0xD2 with last on byte 2; ser_ready=1.
  - Required: ser_data 0x80, 0xD2; first ser_valid at T+5; exactly 1 show_next; ser_eop held until ser_done; pkt_sent pulse; tx_oe low afterwards.
- 12-byte descriptor:
  - Stimulus: 0x80, 0x4b, 0x12, 0x01, 0x00, 0x01, 0xff, 0x00, 0x00, 0x08, 0x23, 0xf3.
  - Required: all 12 delivered in order; 11 show_next pulses; len_err=0.
- Backpressure:
  - Stimulus: ser_ready low for 3 cycles on byte 3.
  - Required: ser_data stable throughout; no extra show_next; byte order intact.
- rx_active cases:
  - rx_active=1 during start_pkt -> drop_cnt 0->1; tx_oe never asserted.
  - rx_active=1 in GAP cycle 2 -> IDLE; no ser_valid; drop_cnt unchanged.
- Guard: last_pkt_byte held 0 -> EOP after 16 accepted bytes; len_err=1 and stays 1 until rst.
- Reset mid-DATA: rst during byte 5 -> next cycle all outputs 0, state IDLE. A subsequent ACK packet is transmitted correctly.
